// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush-to-bubble and a
// saturating bubble counter. Define PIPE_SKID_EN to add a one-entry skid buffer.
module pipe_stage_reg #(
  parameter int INSTR_W = 32,
  parameter int PC_W = 32,
  parameter int PAY_W = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_3000,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [PAY_W-1:0]   in_pay,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [PAY_W-1:0]   out_pay,
  output logic [CNT_W-1:0]   bubble_cnt
);

  logic               main_valid;
  logic [INSTR_W-1:0] main_instr;
  logic [PC_W-1:0]    main_pc;
  logic [PAY_W-1:0]   main_pay;

  logic               take;
  logic               drain;
  logic [INSTR_W-1:0] next_instr;
  logic [PC_W-1:0]    next_pc;
  logic [PAY_W-1:0]   next_pay;

`ifdef PIPE_SKID_EN
  logic               skid_full;
  logic [INSTR_W-1:0] skid_instr;
  logic [PC_W-1:0]    skid_pc;
  logic [PAY_W-1:0]   skid_pay;
  logic               accept;
  logic               main_free;
  logic               from_skid;
  logic               to_skid;

  // in_ready comes straight from a flop, breaking the combinational ready chain
  assign in_ready = ~skid_full;

  always_comb begin
    accept     = in_valid & ~skid_full;
    main_free  = ~main_valid | out_ready;
    from_skid  = skid_full & out_ready;
    to_skid    = accept & ~main_free;
    take       = from_skid | (accept & main_free);
    drain      = main_valid & out_ready & ~take;
    next_instr = in_instr;
    next_pc    = in_pc;
    next_pay   = in_pay;
    if (from_skid) begin
      next_instr = skid_instr;
      next_pc    = skid_pc;
      next_pay   = skid_pay;
    end
  end

  // Skid holds the younger word only while the main register is stalled
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      skid_full  <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= RESET_PC;
      skid_pay   <= '0;
    end else if (to_skid) begin
      skid_full  <= 1'b1;
      skid_instr <= in_instr;
      skid_pc    <= in_pc;
      skid_pay   <= in_pay;
    end else if (from_skid) begin
      skid_full  <= 1'b0;
    end
  end
`else
  assign in_ready = out_ready | ~main_valid;

  always_comb begin
    take       = in_valid & in_ready;
    drain      = main_valid & out_ready & ~take;
    next_instr = in_instr;
    next_pc    = in_pc;
    next_pay   = in_pay;
  end
`endif

  // Priority: reset > flush > load > drain > hold
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      main_valid <= 1'b0;
      main_instr <= '0;
      main_pc    <= RESET_PC;
      main_pay   <= '0;
    end else if (take) begin
      main_valid <= 1'b1;
      main_instr <= next_instr;
      main_pc    <= next_pc;
      main_pay   <= next_pay;
    end else if (drain) begin
      main_valid <= 1'b0;
      main_instr <= '0;
      main_pay   <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt <= '0;
    end else if (!main_valid && (bubble_cnt != '1)) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

  assign out_valid = main_valid;
  assign out_instr = main_instr;
  assign out_pc    = main_pc;
  assign out_pay   = main_pay;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg; skid checks compile in with PIPE_SKID_EN.
module tb_pipe_stage_reg;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_pay;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pay;
  logic [15:0] bubble_cnt;

  logic        s_flush;
  logic        s_in_valid;
  logic        s_in_ready;
  logic [31:0] s_in_instr;
  logic [31:0] s_in_pc;
  logic [31:0] s_in_pay;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [31:0] s_out_instr;
  logic [31:0] s_out_pc;
  logic [31:0] s_out_pay;
  logic [3:0]  s_bubble_cnt;

  int compared;
  int mismatched;

  pipe_stage_reg dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_pay(in_pay),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_pay(out_pay),
    .bubble_cnt(bubble_cnt)
  );

  pipe_stage_reg #(.CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .flush(s_flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_instr(s_in_instr), .in_pc(s_in_pc), .in_pay(s_in_pay),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_instr(s_out_instr), .out_pc(s_out_pc), .out_pay(s_out_pay),
    .bubble_cnt(s_bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0; in_pay = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    compared += 6;
    if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid got %b want 0", out_valid); end
    if (out_pc !== 32'h3000) begin mismatched++; $display("[TB] FAIL reset_pc got %h want 00003000", out_pc); end
    if (out_instr !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_instr got %h want 0", out_instr); end
    if (out_pay !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_pay got %h want 0", out_pay); end
    if (bubble_cnt !== 16'd0) begin mismatched++; $display("[TB] FAIL reset_cnt got %0d want 0", bubble_cnt); end
    if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_counter();
    do_reset();
    out_ready = 1'b1;
    repeat (5) step();
    compared += 2;
    if (s_bubble_cnt !== 4'd5) begin mismatched++; $display("[TB] FAIL cnt4_at5 got %0d want 5", s_bubble_cnt); end
    if (bubble_cnt !== 16'd5) begin mismatched++; $display("[TB] FAIL cnt16_at5 got %0d want 5", bubble_cnt); end
    repeat (15) step();
    compared += 2;
    if (s_bubble_cnt !== 4'd15) begin mismatched++; $display("[TB] FAIL cnt4_at20 got %0d want 15", s_bubble_cnt); end
    if (bubble_cnt !== 16'd20) begin mismatched++; $display("[TB] FAIL cnt16_at20 got %0d want 20", bubble_cnt); end
    repeat (3) step();
    compared++;
    if (s_bubble_cnt !== 4'd15) begin mismatched++; $display("[TB] FAIL cnt4_sat got %0d want 15", s_bubble_cnt); end
  endtask

  task automatic test_stream();
    logic [31:0] pcs [3];
    logic [31:0] ins [3];
    logic [31:0] pys [3];
    pcs = '{32'h3000, 32'h3004, 32'h3008};
    ins = '{32'h0000_0013, 32'h0040_0093, 32'h0080_0113};
    pys = '{32'h0000_0011, 32'h0000_0022, 32'h0000_0033};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pc = pcs[i]; in_instr = ins[i]; in_pay = pys[i];
      compared++;
      if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL stream_ready[%0d] got %b want 1", i, in_ready); end
      step();
      compared += 4;
      if (out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL stream_valid[%0d] got %b want 1", i, out_valid); end
      if (out_pc !== pcs[i]) begin mismatched++; $display("[TB] FAIL stream_pc[%0d] got %h want %h", i, out_pc, pcs[i]); end
      if (out_instr !== ins[i]) begin mismatched++; $display("[TB] FAIL stream_instr[%0d] got %h want %h", i, out_instr, ins[i]); end
      if (out_pay !== pys[i]) begin mismatched++; $display("[TB] FAIL stream_pay[%0d] got %h want %h", i, out_pay, pys[i]); end
    end
    in_valid = 1'b0;
    step();
    compared += 5;
    if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL drain_valid got %b want 0", out_valid); end
    if (out_instr !== 32'h0) begin mismatched++; $display("[TB] FAIL drain_instr got %h want 0", out_instr); end
    if (out_pay !== 32'h0) begin mismatched++; $display("[TB] FAIL drain_pay got %h want 0", out_pay); end
    if (out_pc !== 32'h3008) begin mismatched++; $display("[TB] FAIL drain_pc got %h want 00003008", out_pc); end
    if (bubble_cnt !== 16'd1) begin mismatched++; $display("[TB] FAIL stream_cnt got %0d want 1", bubble_cnt); end
  endtask

  task automatic test_stall();
    logic exp_ready;
    do_reset();
    in_valid = 1'b1; in_pc = 32'h3004; in_instr = 32'h0040_0093; in_pay = 32'h0000_00a5;
    step();
    in_pc = 32'h3008; in_instr = 32'h0080_0113; in_pay = 32'h0000_005a;
    for (int i = 0; i < 3; i++) begin
`ifdef PIPE_SKID_EN
      exp_ready = (i == 0);
`else
      exp_ready = 1'b0;
`endif
      compared++;
      if (in_ready !== exp_ready) begin mismatched++; $display("[TB] FAIL stall_ready[%0d] got %b want %b", i, in_ready, exp_ready); end
      step();
      compared += 4;
      if (out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL stall_valid[%0d] got %b want 1", i, out_valid); end
      if (out_pc !== 32'h3004) begin mismatched++; $display("[TB] FAIL stall_pc[%0d] got %h want 00003004", i, out_pc); end
      if (out_instr !== 32'h0040_0093) begin mismatched++; $display("[TB] FAIL stall_instr[%0d] got %h want 00400093", i, out_instr); end
      if (out_pay !== 32'h0000_00a5) begin mismatched++; $display("[TB] FAIL stall_pay[%0d] got %h want 000000a5", i, out_pay); end
    end
    compared++;
    if (bubble_cnt !== 16'd1) begin mismatched++; $display("[TB] FAIL stall_cnt got %0d want 1", bubble_cnt); end
    out_ready = 1'b1;
    step();
    compared += 2;
    if (out_pc !== 32'h3008) begin mismatched++; $display("[TB] FAIL release_pc got %h want 00003008", out_pc); end
    if (out_pay !== 32'h0000_005a) begin mismatched++; $display("[TB] FAIL release_pay got %h want 0000005a", out_pay); end
    in_valid = 1'b0;
    step();
    compared++;
    if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL release_drain got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1'b1; in_pc = 32'h3004; in_instr = 32'h1234_5678; in_pay = 32'h0000_0077;
    step();
    flush = 1'b1; in_pc = 32'h3010; in_instr = 32'h0bad_0bad; in_pay = 32'h0000_0099;
    step();
    compared += 4;
    if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_valid got %b want 0", out_valid); end
    if (out_instr !== 32'h0) begin mismatched++; $display("[TB] FAIL flush_instr got %h want 0", out_instr); end
    if (out_pay !== 32'h0) begin mismatched++; $display("[TB] FAIL flush_pay got %h want 0", out_pay); end
    if (out_pc !== 32'h3000) begin mismatched++; $display("[TB] FAIL flush_pc got %h want 00003000", out_pc); end
    flush = 1'b0; in_valid = 1'b0;
    step();
    compared += 2;
    if (bubble_cnt !== 16'd2) begin mismatched++; $display("[TB] FAIL flush_cnt got %0d want 2", bubble_cnt); end
    if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL flush_ready got %b want 1", in_ready); end
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    step();
    compared += 2;
    if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_drop got %b want 0", out_valid); end
    if (out_pc !== 32'h3000) begin mismatched++; $display("[TB] FAIL flush_drop_pc got %h want 00003000", out_pc); end
    flush = 1'b0; in_valid = 1'b0;
  endtask

`ifdef PIPE_SKID_EN
  task automatic test_skid();
    do_reset();
    in_valid = 1'b1; in_pc = 32'h3100; in_instr = 32'haaaa_0001; in_pay = 32'h1;
    step();
    in_pc = 32'h3104; in_instr = 32'hbbbb_0002; in_pay = 32'h2;
    step();
    compared += 2;
    if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL skid_full_ready got %b want 0", in_ready); end
    if (out_pc !== 32'h3100) begin mismatched++; $display("[TB] FAIL skid_hold_a got %h want 00003100", out_pc); end
    in_pc = 32'h3108; in_instr = 32'hcccc_0003; in_pay = 32'h3;
    step();
    compared++;
    if (out_pc !== 32'h3100) begin mismatched++; $display("[TB] FAIL skid_hold_a2 got %h want 00003100", out_pc); end
    out_ready = 1'b1;
    step();
    compared += 3;
    if (out_pc !== 32'h3104) begin mismatched++; $display("[TB] FAIL skid_out_b got %h want 00003104", out_pc); end
    if (out_instr !== 32'hbbbb_0002) begin mismatched++; $display("[TB] FAIL skid_out_b_instr got %h want bbbb0002", out_instr); end
    if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL skid_ready_back got %b want 1", in_ready); end
    step();
    compared++;
    if (out_pc !== 32'h3108) begin mismatched++; $display("[TB] FAIL skid_out_c got %h want 00003108", out_pc); end
    in_valid = 1'b0;
    step();
    compared++;
    if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL skid_drain got %b want 0", out_valid); end
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h3200;
    step();
    in_pc = 32'h3204;
    step();
    in_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0; out_ready = 1'b1;
    step();
    compared += 2;
    if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL skid_flush_valid got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL skid_flush_ready got %b want 1", in_ready); end
  endtask
`endif

  initial begin
    compared = 0;
    mismatched = 0;
    s_flush = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b1;
    s_in_instr = '0; s_in_pc = '0; s_in_pay = '0;
    test_reset();
    test_counter();
    test_stream();
    test_stall();
    test_flush();
`ifdef PIPE_SKID_EN
    test_skid();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
